// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared types, constants and the digit-count helper for the
//                sequential binary-to-BCD converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Smallest digit count d with 10**d > 2**w - 1 (valid for w < 64).
    function automatic int digits_for_width(input int w);
        longint unsigned max_val;
        longint unsigned pow10;
        int              d;
        max_val = (64'd1 << w) - 64'd1;
        pow10   = 64'd1;
        d       = 0;
        for (int i = 0; i < 20; i++) begin
            if (pow10 <= max_val) begin
                pow10 = pow10 * 64'd10;
                d     = d + 1;
            end
        end
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq_if
//  Description : Request/result bundle between a producer and the converter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      value;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     display_write;

    modport master (
        output start, value,
        input  busy, done, bcd, display_write
    );

    modport slave (
        input  start, value,
        output busy, done, bcd, display_write
    );
endinterface
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3
//  Description : Double-dabble correction for one BCD nibble (>=5 gets +3).
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3 (
    input  wire logic [3:0] i_nibble,
    output logic      [3:0] o_nibble
);
    // 9 + 3 = 4'hC at most, so the nibble never carries into its neighbour.
    assign o_nibble = (i_nibble >= 4'd5) ? (i_nibble + 4'd3) : i_nibble;
endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Shift-and-add-3 binary-to-BCD converter, one bit per clock,
//                feeding a bank of per-digit seven-segment decoders.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  wire logic       clk,
    input  wire logic       reset,
    bin_to_bcd_seq_if.slave bus
);
    localparam int c_scr_w = NIBBLE_W * DIGITS;
    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(1);

    generate
        if (DIGITS < digits_for_width(WIDTH)) begin : g_digits_check
            $error("bin_to_bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
        end
    endgenerate

    state_t                 r_state;
    logic [WIDTH-1:0]       r_shreg;
    logic [c_scr_w-1:0]     r_scratch;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic [DIGITS-1:0]      r_display_write;
    logic [c_scr_w-1:0]     r_bcd;

    logic [c_scr_w-1:0]         w_adj;
    logic [c_scr_w+WIDTH-1:0]   w_cat;
    logic [c_scr_w+WIDTH-1:0]   w_cat_sh;
    logic [c_scr_w-1:0]         w_scratch_next;
    logic [WIDTH-1:0]           w_shreg_next;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_nibble
            bcd_add3 u_add3 (
                .i_nibble (r_scratch[NIBBLE_W*k +: NIBBLE_W]),
                .o_nibble (w_adj[NIBBLE_W*k +: NIBBLE_W])
            );
        end
    endgenerate

    assign w_cat          = {w_adj, r_shreg};
    assign w_cat_sh       = w_cat << 1;
    assign w_scratch_next = w_cat_sh[c_scr_w+WIDTH-1:WIDTH];
    assign w_shreg_next   = w_cat_sh[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_shreg         <= '0;
            r_scratch       <= '0;
            r_cnt           <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_display_write <= '0;
            r_bcd           <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done          <= 1'b0;
                    r_display_write <= '0;
                    if (bus.start) begin
                        r_shreg   <= bus.value;
                        r_scratch <= '0;
                        r_cnt     <= c_cnt_init;
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_scratch <= w_scratch_next;
                    r_shreg   <= w_shreg_next;
                    r_cnt     <= r_cnt - c_cnt_last;
                    // Result is registered on the last shift so it is valid in the DONE cycle.
                    if (r_cnt == c_cnt_last) begin
                        r_state         <= DONE;
                        r_bcd           <= w_scratch_next;
                        r_done          <= 1'b1;
                        r_display_write <= '1;
                    end
                end
                DONE: begin
                    r_done          <= 1'b0;
                    r_display_write <= '0;
                    r_busy          <= 1'b0;
                    r_state         <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.bcd           = r_bcd;
    assign bus.display_write = r_display_write;

endmodule
`default_nettype wire
